// File: rtl/mips_load_pkg.sv
// Shared types and helpers for the MIPS load sequencer/aligner.
//   load_type_t   : encoding of the load_type request field
//   state_t       : sequencer states
//   is_misaligned : flags illegal type or an offset the access width cannot use
package mips_load_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        LB      = 3'd0,
        LBU     = 3'd1,
        LH      = 3'd2,
        LHU     = 3'd3,
        LW      = 3'd4,
        LWL     = 3'd5,
        LWR     = 3'd6,
        ILLEGAL = 3'd7
    } load_type_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ALIGN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Halfwords need an even offset, words need offset 0; LWL/LWR take any offset.
    function automatic logic is_misaligned(load_type_t t, logic [1:0] off);
        logic bad;
        case (t)
            LH, LHU: bad = off[0];
            LW:      bad = (off != 2'd0);
            ILLEGAL: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_cpu_load_align_unit_if.sv
// Request + memory-bus bundle for the load align unit.
//   master : the load unit (drives mem_read and the writeback results)
//   slave  : the surrounding datapath / memory model
interface mips_cpu_load_align_unit_if
    import mips_load_pkg::*;
();
    logic              start;
    logic [2:0]        load_type;
    logic [1:0]        byte_offset;
    logic [DATA_W-1:0] rt_old;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_waitrequest;
    logic              mem_read;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              busy;
    logic              align_error;

    modport master (
        input  start, load_type, byte_offset, rt_old, mem_readdata, mem_waitrequest,
        output mem_read, result, result_valid, busy, align_error
    );

    modport slave (
        output start, load_type, byte_offset, rt_old, mem_readdata, mem_waitrequest,
        input  mem_read, result, result_valid, busy, align_error
    );
endinterface

// File: rtl/mips_load_extract.sv
// Combinational load-data extraction/merge (little-endian byte lanes).
//   load_type, offset : latched request
//   mdr               : captured memory word
//   rt_old            : latched rt value for LWL/LWR merge
//   value_c           : writeback value
module mips_load_extract
    import mips_load_pkg::*;
(
    input  load_type_t        load_type,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] mdr,
    input  logic [DATA_W-1:0] rt_old,
    output logic [DATA_W-1:0] value_c
);
    localparam logic [DATA_W-1:0] ONES = '1;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [4:0]        lwl_sh;
    logic [4:0]        lwr_sh;
    logic [DATA_W-1:0] lwl_val;
    logic [DATA_W-1:0] lwr_val;

    always_comb begin
        byte_sel = mdr[{offset, 3'b000} +: 8];
        half_sel = mdr[{offset[1], 4'b0000} +: 16];
        // 8*(3-k) == {~k, 3'b0} for a 2-bit k
        lwl_sh   = {~offset, 3'b000};
        lwr_sh   = {offset, 3'b000};
        lwl_val  = (mdr << lwl_sh) | (rt_old & ~(ONES << lwl_sh));
        lwr_val  = (mdr >> lwr_sh) | (rt_old & ~(ONES >> lwr_sh));

        value_c = mdr;
        case (load_type)
            LB:      value_c = {{24{byte_sel[7]}}, byte_sel};
            LBU:     value_c = {24'd0, byte_sel};
            LH:      value_c = {{16{half_sel[15]}}, half_sel};
            LHU:     value_c = {16'd0, half_sel};
            LWL:     value_c = lwl_val;
            LWR:     value_c = lwr_val;
            default: value_c = mdr;
        endcase
    end

endmodule

// File: rtl/mips_cpu_load_align_unit.sv
// Memory-read sequencer and load aligner for the multi-cycle MIPS datapath.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request (start/load_type/byte_offset/rt_old), memory bus
//                (mem_read/mem_readdata/mem_waitrequest) and writeback
//                (result/result_valid/busy/align_error); all outputs registered.
module mips_cpu_load_align_unit
    import mips_load_pkg::*;
#(
    parameter int unsigned DATA_W = mips_load_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    mips_cpu_load_align_unit_if.master   bus
);
    state_t              state_q, state_d;
    load_type_t          type_q, type_d;
    logic [1:0]          off_q, off_d;
    logic [DATA_W-1:0]   rt_q, rt_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                mem_read_q, mem_read_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                align_error_q, align_error_d;
    logic [DATA_W-1:0]   extract_c;
    load_type_t          req_type;

    assign req_type = load_type_t'(bus.load_type);

    mips_load_extract u_extract (
        .load_type (type_q),
        .offset    (off_q),
        .mdr       (mdr_q),
        .rt_old    (rt_q),
        .value_c   (extract_c)
    );

    // Next-state and next-output logic; outputs are decoded from the next state
    // so they appear registered in the same cycle the state is entered.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        off_d    = off_q;
        rt_d     = rt_q;
        mdr_d    = mdr_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    type_d  = req_type;
                    off_d   = bus.byte_offset;
                    rt_d    = bus.rt_old;
                    state_d = is_misaligned(req_type, bus.byte_offset) ? ERR : READ;
                end
            end
            READ: begin
                if (!bus.mem_waitrequest) begin
                    mdr_d   = bus.mem_readdata;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                result_d = extract_c;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_read_d     = (state_d == READ);
        result_valid_d = (state_d == DONE);
        align_error_d  = (state_d == ERR);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            type_q         <= LB;
            off_q          <= 2'd0;
            rt_q           <= '0;
            mdr_q          <= '0;
            result_q       <= '0;
            mem_read_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            align_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            off_q          <= off_d;
            rt_q           <= rt_d;
            mdr_q          <= mdr_d;
            result_q       <= result_d;
            mem_read_q     <= mem_read_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            align_error_q  <= align_error_d;
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.align_error  = align_error_q;

endmodule

// File: tb/tb_mips_cpu_load_align_unit.sv
// Directed bench for the load align unit: extraction per type/offset,
// latency with wait states, busy-start rejection, error pulses and mid-read reset.
module tb_mips_cpu_load_align_unit;

    localparam logic [31:0] RD      = 32'h8899AABB;
    localparam logic [31:0] GARBAGE = 32'h5A5A5A5A;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mips_cpu_load_align_unit_if bus ();

    mips_cpu_load_align_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full load: start in cycle T, then walk cycles T+1.. checking latency,
    // read-strobe length, result, and that a start pulsed while busy is dropped.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] k,
                           input logic [31:0] rt, input int waits, input logic [31:0] exp);
        int c;
        int reads;
        int valid_at;
        next_cycle();
        bus.start           = 1'b1;
        bus.load_type       = lt;
        bus.byte_offset     = k;
        bus.rt_old          = rt;
        bus.mem_waitrequest = (waits > 0);
        bus.mem_readdata    = GARBAGE;
        next_cycle();
        bus.start       = 1'b0;
        bus.load_type   = 3'd0;
        bus.byte_offset = 2'd0;
        bus.rt_old      = 32'hDEADBEEF;
        c        = 1;
        reads    = 0;
        valid_at = -1;
        while (c < 20) begin
            bus.mem_waitrequest = (c <= waits);
            bus.mem_readdata    = (c == waits + 1) ? RD : GARBAGE;
            bus.start           = (c == 2);
            if (c == 1) check_eq({tag, ":busy_t1"}, 32'(bus.busy), 32'd1);
            if (bus.mem_read) reads++;
            if (bus.result_valid) begin
                valid_at = c;
                break;
            end
            next_cycle();
            c++;
        end
        bus.start = 1'b0;
        check_eq({tag, ":valid_at"}, 32'(valid_at), 32'(waits + 3));
        check_eq({tag, ":read_cycles"}, 32'(reads), 32'(waits + 1));
        check_eq({tag, ":result"}, bus.result, exp);
        next_cycle();
        check_eq({tag, ":valid_pulse"}, 32'(bus.result_valid), 32'd0);
        check_eq({tag, ":idle_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ":no_requeue"}, 32'(bus.mem_read), 32'd0);
        check_eq({tag, ":hold"}, bus.result, exp);
    endtask

    // Illegal request: error pulse at T+1, no bus read, result untouched.
    task automatic do_err(input string tag, input logic [2:0] lt, input logic [1:0] k);
        logic [31:0] prev;
        prev = bus.result;
        next_cycle();
        bus.start       = 1'b1;
        bus.load_type   = lt;
        bus.byte_offset = k;
        bus.rt_old      = 32'h01020304;
        next_cycle();
        bus.start = 1'b0;
        check_eq({tag, ":err_t1"}, 32'(bus.align_error), 32'd1);
        check_eq({tag, ":rd_t1"}, 32'(bus.mem_read), 32'd0);
        check_eq({tag, ":busy_t1"}, 32'(bus.busy), 32'd1);
        next_cycle();
        check_eq({tag, ":err_t2"}, 32'(bus.align_error), 32'd0);
        check_eq({tag, ":rd_t2"}, 32'(bus.mem_read), 32'd0);
        check_eq({tag, ":busy_t2"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ":result"}, bus.result, prev);
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        reset               = 1'b1;
        bus.start           = 1'b0;
        bus.load_type       = 3'd0;
        bus.byte_offset     = 2'd0;
        bus.rt_old          = '0;
        bus.mem_readdata    = GARBAGE;
        bus.mem_waitrequest = 1'b0;
        next_cycle();
        next_cycle();
        check_eq("rst:mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("rst:result", bus.result, 32'd0);
        check_eq("rst:valid", 32'(bus.result_valid), 32'd0);
        check_eq("rst:busy", 32'(bus.busy), 32'd0);
        check_eq("rst:err", 32'(bus.align_error), 32'd0);
        reset = 1'b0;

        do_load("lb_k1",  3'd0, 2'd1, 32'h11223344, 0, 32'hFFFFFFAA);
        do_load("lbu_k3", 3'd1, 2'd3, 32'h11223344, 0, 32'h00000088);
        do_load("lb_k0",  3'd0, 2'd0, 32'h11223344, 0, 32'hFFFFFFBB);
        do_load("lh_k2",  3'd2, 2'd2, 32'h11223344, 0, 32'hFFFF8899);
        do_load("lhu_k0", 3'd3, 2'd0, 32'h11223344, 0, 32'h0000AABB);
        do_load("lwl_k1", 3'd5, 2'd1, 32'h11223344, 0, 32'hAABB3344);
        do_load("lwr_k1", 3'd6, 2'd1, 32'h11223344, 0, 32'h118899AA);
        do_load("lwl_k3", 3'd5, 2'd3, 32'h11223344, 0, 32'h8899AABB);
        do_load("lwr_k0", 3'd6, 2'd0, 32'h11223344, 0, 32'h8899AABB);
        do_load("lwl_k0", 3'd5, 2'd0, 32'h11223344, 1, 32'hBB223344);
        do_load("lwr_k3", 3'd6, 2'd3, 32'h11223344, 2, 32'h11223388);
        do_load("lw_w3",  3'd4, 2'd0, 32'h11223344, 3, 32'h8899AABB);

        do_err("lw_k2",   3'd4, 2'd2);
        do_err("lh_k1",   3'd2, 2'd1);
        do_err("illegal", 3'd7, 2'd0);

        // Reset while stalled in READ.
        next_cycle();
        bus.start           = 1'b1;
        bus.load_type       = 3'd4;
        bus.byte_offset     = 2'd0;
        bus.mem_waitrequest = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        check_eq("mid_rst:read_t1", 32'(bus.mem_read), 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_eq("mid_rst:mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("mid_rst:result", bus.result, 32'd0);
        check_eq("mid_rst:busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst:valid", 32'(bus.result_valid), 32'd0);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = RD;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check_eq("mid_rst:no_valid", 32'(bus.result_valid), 32'd0);
        end
        do_load("post_rst_lhu_k2", 3'd3, 2'd2, 32'h0, 0, 32'h00008899);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_load_align_unit.md
Name: mips_cpu_load_align_unit

Overview:
- Memory-read sequencer and load-data aligner for the multi-cycle MIPS datapath, downstream of the 2-bit byte-offset register that holds ALU-out[1:0].
- Issues one bus read, waits out waitrequest and captures the word into an internal memory-data register.
- Extracts or merges the addressed byte, halfword or word using the stored offset, and hands a register-writeback value to the register file.
- Byte addressing is little-endian: offset 0 selects readdata[7:0].

Parameters:
- DATA_W, 32, word width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request pulse; sampled only in IDLE
- load_type  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR 7=illegal
- byte_offset  in  2  output of the 2-bit offset register
- rt_old  in  32  current rt value, used for the LWL/LWR merge
- mem_readdata  in  32  bus read data
- mem_waitrequest  in  1  bus stall
- mem_read  out  1  bus read strobe
- result  out  32  writeback value
- result_valid  out  1  one-cycle pulse when result is valid
- busy  out  1  high in any state other than IDLE
- align_error  out  1  one-cycle pulse on a misaligned access or illegal load_type

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; state=IDLE; internal registers 0.
- A reset asserted in any state, including mid-wait, returns the block to IDLE at that edge. mem_read is low from the following cycle and no result_valid is produced.
- States and transitions:
  - IDLE: on start, latch load_type, byte_offset and rt_old.
    - If illegal, go to ERR. Illegal means load_type=7, LH/LHU with offset[0]=1, or LW with offset!=0.
    - Otherwise go to READ.
    - start while busy is ignored and is not queued.
  - READ: mem_read=1.
    - If mem_waitrequest=0 at the edge, capture mem_readdata into the MDR and go to ALIGN.
    - Otherwise stay in READ with mem_read held high. There is no timeout.
  - ALIGN: register result from the MDR, the latched type and the latched offset; go to DONE.
  - DONE: result_valid=1 for exactly one cycle; go to IDLE.
  - ERR: align_error=1 for exactly one cycle; mem_read is never asserted; result is unchanged; go to IDLE.
- Latency: start at cycle T gives READ at T+1. With zero wait states, result_valid is at T+3. Each waitrequest cycle adds 1.
- result holds its value until the next DONE.
- Extraction rules, with k = byte_offset and m = MDR:
  - LB: sign-extend m[8k+7:8k].
  - LBU: zero-extend m[8k+7:8k].
  - LH: sign-extend m[8k+15:8k], where k is 0 or 2.
  - LHU: zero-extend m[8k+15:8k].
  - LW: m.
  - LWL: (m << 8*(3-k)) | (rt_old & low-mask of 8*(3-k) bits). k=3 gives m.
  - LWR: (m >> 8k) | (rt_old & high-mask of 8k bits). k=0 gives m.
- The latched rt_old is used, not the live input.
- mem_readdata is ignored outside a READ cycle with waitrequest=0.

Decomposition:
- Package mips_load_pkg:
  - load_type_t enum (LB..LWR, ILLEGAL=7)
  - state_t enum (IDLE, READ, ALIGN, DONE, ERR)
  - function is_misaligned(load_type_t, logic[1:0])
- Sub-module mips_load_extract: purely combinational extraction and merge of (type, offset, m, rt_old) into a 32-bit value. It is instantiated once and feeds the ALIGN register, so it can be unit-tested in isolation.

Test Plan:
- LB, k=1, readdata=0x8899AABB, waitrequest=0 -> result=0xFFFFFFAA, result_valid at T+3; LBU k=3 -> 0x00000088.
- LH k=2 -> 0xFFFF8899; LHU k=0 -> 0x0000AABB.
- LWL k=1, rt_old=0x11223344 -> 0xAABB3344; LWR k=1 -> 0x118899AA; LWL k=3 and LWR k=0 -> 0x8899AABB.
- LW k=0 with waitrequest held for 3 cycles -> mem_read high for 4 cycles, result_valid at T+6, result=0x8899AABB; start pulsed while busy has no effect.
- LW k=2, LH k=1 and load_type=7 -> align_error pulse at T+1, mem_read never high, result unchanged, busy low at T+2.
- Reset asserted in READ while waitrequest=1 -> mem_read low next cycle, no result_valid, outputs 0; a new start then completes normally.
